imem_loader: RTL

Byte-stream boot loader that writes a program into the instruction memory's write port before the core starts fetching. It accepts bytes over a valid/ready stream and assembles little-endian 32-bit instruction words. Each word is written to consecutive word-aligned addresses starting at 0. While loading, it holds the core in stall, so the fetch path only ever reads a fully written program.

---
 rtl/imem_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Byte-stream boot loader. Assembles little-endian 32-bit words
//               from a valid/ready byte stream and writes them to consecutive
//               word-aligned instruction memory addresses starting at 0,
//               holding the core in stall until the whole program is in.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int INSTRUCTION_SIZE = 32,
  parameter int MEM_DEPTH        = 256,
  parameter int LEN_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_start,
  input  logic [LEN_WIDTH-1:0]        load_len,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_data,
  output logic                        byte_ready,
  output logic                        imem_we,
  output logic [31:0]                 imem_addr,
  output logic [INSTRUCTION_SIZE-1:0] imem_wdata,
  output logic                        cpu_stall,
  output logic                        busy,
  output logic                        load_done,
  output logic                        load_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // One extra bit so a length of exactly MEM_DEPTH is representable.
  localparam logic [LEN_WIDTH:0] c_memDepth = (LEN_WIDTH+1)'(MEM_DEPTH);

  state_t                      r_state;
  state_t                      w_nextState;
  logic [LEN_WIDTH-1:0]        r_len;
  logic [LEN_WIDTH-1:0]        r_wordCnt;
  logic [1:0]                  r_byteCnt;
  logic [INSTRUCTION_SIZE-1:0] r_buffer;
  logic                        r_loadErr;

  logic w_lenTooBig;
  logic w_lenZero;
  logic w_accept;
  logic w_lastWord;

  assign w_lenTooBig = {1'b0, load_len} > c_memDepth;
  assign w_lenZero   = (load_len == '0);
  assign w_accept    = byte_valid && (r_state == S_RECV);
  assign w_lastWord  = ((r_wordCnt + LEN_WIDTH'(1)) == r_len);

  // Address and data come straight from registers; the length check keeps
  // r_wordCnt inside the memory so no wrap handling is needed.
  assign imem_addr  = 32'(r_wordCnt) << 2;
  assign imem_wdata = r_buffer;
  assign load_err   = r_loadErr;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_nextState = r_state;
    byte_ready  = 1'b0;
    imem_we     = 1'b0;
    cpu_stall   = 1'b0;
    busy        = 1'b0;
    load_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_start && !w_lenTooBig) begin
          w_nextState = w_lenZero ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        byte_ready = 1'b1;
        cpu_stall  = 1'b1;
        busy       = 1'b1;
        if (w_accept && (r_byteCnt == 2'd3)) begin
          w_nextState = S_WRITE;
        end
      end
      S_WRITE: begin
        imem_we     = 1'b1;
        cpu_stall   = 1'b1;
        busy        = 1'b1;
        w_nextState = w_lastWord ? S_DONE : S_RECV;
      end
      S_DONE: begin
        load_done   = 1'b1;
        cpu_stall   = 1'b1;
        busy        = 1'b1;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Length latch, word/byte counters, word buffer and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len     <= '0;
      r_wordCnt <= '0;
      r_byteCnt <= '0;
      r_buffer  <= '0;
      r_loadErr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            if (w_lenTooBig) begin
              r_loadErr <= 1'b1;
            end else begin
              r_loadErr <= 1'b0;
              r_len     <= load_len;
              r_wordCnt <= '0;
              r_byteCnt <= '0;
            end
          end
        end
        S_RECV: begin
          if (w_accept) begin
            r_buffer[8*r_byteCnt +: 8] <= byte_data;
            r_byteCnt                  <= r_byteCnt + 2'd1;
          end
        end
        S_WRITE: begin
          r_wordCnt <= r_wordCnt + LEN_WIDTH'(1);
          r_byteCnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
